// File: rtl/rh_temp_scaler_if.sv
// rh_temp_scaler_if: sample/result bundle between RH_TEMP, the scaler and display/HPS logic
// master drives SAMPLE_VALID, TEMP_RAW, RH_RAW, CLEAR and observes the results.
// slave (the scaler) drives TEMP_OUT, RH_OUT, OUT_VALID, TEMP_MIN, TEMP_MAX, BUSY, OVERRUN.
interface rh_temp_scaler_if;
  logic        SAMPLE_VALID;
  logic [15:0] TEMP_RAW;
  logic [15:0] RH_RAW;
  logic        CLEAR;
  logic [15:0] TEMP_OUT;
  logic [15:0] RH_OUT;
  logic        OUT_VALID;
  logic [15:0] TEMP_MIN;
  logic [15:0] TEMP_MAX;
  logic        BUSY;
  logic        OVERRUN;
  modport master (
    output SAMPLE_VALID, TEMP_RAW, RH_RAW, CLEAR,
    input  TEMP_OUT, RH_OUT, OUT_VALID, TEMP_MIN, TEMP_MAX, BUSY, OVERRUN
  );
  modport slave (
    input  SAMPLE_VALID, TEMP_RAW, RH_RAW, CLEAR,
    output TEMP_OUT, RH_OUT, OUT_VALID, TEMP_MIN, TEMP_MAX, BUSY, OVERRUN
  );
endinterface

// File: rtl/rh_temp_scaler.sv
// rh_temp_scaler: averages raw HDC1000 codes and scales them to fixed-point temperature/humidity
// CLOCK_50 : system clock, rising edge
// RESET_N  : asynchronous active-low reset
// bus      : slave side of rh_temp_scaler_if (raw samples in; scaled results, min/max, BUSY, OVERRUN out)
module rh_temp_scaler #(
  parameter int AVG_LOG2 = 2,
  parameter int SCALE    = 10
) (
  input logic            CLOCK_50,
  input logic            RESET_N,
  rh_temp_scaler_if.slave bus
);
  localparam int SW = 16 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [31:0] KT  = 32'(165 * SCALE);
  localparam logic [31:0] KRH = 32'(100 * SCALE);
  localparam logic [15:0] OFS = 16'(40 * SCALE);
  typedef enum logic [1:0] {COLLECT, MULT, LOAD} state_t;
  state_t state, state_nx;
  logic [SW-1:0] sum_t, sum_rh, sum_t_nx, sum_rh_nx;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   avg_t, avg_rh, t_new;
  logic [31:0]   prod_t, prod_rh;
  logic          take, last, mm_armed;
  assign take      = bus.SAMPLE_VALID && state == COLLECT;
  assign last      = cnt == CW'((1 << AVG_LOG2) - 1);
  assign sum_t_nx  = sum_t + SW'(bus.TEMP_RAW);
  assign sum_rh_nx = sum_rh + SW'(bus.RH_RAW);
  assign t_new     = prod_t[31:16] - OFS;
  assign bus.BUSY  = state != COLLECT;
  always_comb begin
    state_nx = state;
    state_nx = state == COLLECT ? (take && last ? MULT : COLLECT) :
               state == MULT    ? (bit_cnt == 4'd15 ? LOAD : MULT) : COLLECT;
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= COLLECT;
    else state <= state_nx;
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sum_t        <= '0;
      sum_rh       <= '0;
      cnt          <= '0;
      bit_cnt      <= '0;
      avg_t        <= '0;
      avg_rh       <= '0;
      prod_t       <= '0;
      prod_rh      <= '0;
      mm_armed     <= 1'b0;
      bus.TEMP_OUT  <= '0;
      bus.RH_OUT    <= '0;
      bus.OUT_VALID <= 1'b0;
      bus.TEMP_MIN  <= 16'h7FFF;
      bus.TEMP_MAX  <= 16'h8000;
      bus.OVERRUN   <= 1'b0;
    end else begin
      bus.OUT_VALID <= 1'b0;
      // a dropped sample outranks a simultaneous CLEAR
      if (bus.SAMPLE_VALID && bus.BUSY) bus.OVERRUN <= 1'b1;
      else if (bus.CLEAR) bus.OVERRUN <= 1'b0;
      if (take && last) begin
        sum_t   <= '0;
        sum_rh  <= '0;
        cnt     <= '0;
        bit_cnt <= '0;
        prod_t  <= '0;
        prod_rh <= '0;
        avg_t   <= 16'(sum_t_nx >> AVG_LOG2);
        avg_rh  <= 16'(sum_rh_nx >> AVG_LOG2);
      end else if (take) begin
        sum_t  <= sum_t_nx;
        sum_rh <= sum_rh_nx;
        cnt    <= cnt + CW'(1);
      end
      // shift-add: averages are consumed LSB first, constant shifted by bit position
      if (state == MULT) begin
        prod_t  <= prod_t + (avg_t[0] ? KT << bit_cnt : 32'd0);
        prod_rh <= prod_rh + (avg_rh[0] ? KRH << bit_cnt : 32'd0);
        avg_t   <= avg_t >> 1;
        avg_rh  <= avg_rh >> 1;
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (bus.CLEAR) begin
        mm_armed     <= 1'b0;
        bus.TEMP_MIN <= 16'h7FFF;
        bus.TEMP_MAX <= 16'h8000;
      end
      // a CLEAR coinciding with LOAD still lets this result seed min/max
      if (state == LOAD) begin
        bus.TEMP_OUT  <= t_new;
        bus.RH_OUT    <= prod_rh[31:16];
        bus.OUT_VALID <= 1'b1;
        mm_armed      <= 1'b1;
        if (!mm_armed || bus.CLEAR || $signed(t_new) < $signed(bus.TEMP_MIN)) bus.TEMP_MIN <= t_new;
        if (!mm_armed || bus.CLEAR || $signed(t_new) > $signed(bus.TEMP_MAX)) bus.TEMP_MAX <= t_new;
      end
    end
  end
endmodule

// File: tb/tb_rh_temp_scaler.sv
// tb_rh_temp_scaler: three scaler configurations driven in parallel and checked against a timeline model
module tb_rh_temp_scaler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, sv, clr;
  logic [15:0] traw, rhraw;
  logic [15:0] t_out[3], rh_out[3], mn[3], mx[3];
  logic o_valid[3], busy[3], ovr[3];
  rh_temp_scaler_if ifs[3] ();
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    rh_temp_scaler #(.AVG_LOG2(g == 1 ? 2 : 0), .SCALE(g == 2 ? 100 : 10)) dut (
      .CLOCK_50(clk), .RESET_N(rst_n), .bus(ifs[g])
    );
    assign ifs[g].SAMPLE_VALID = sv;
    assign ifs[g].TEMP_RAW     = traw;
    assign ifs[g].RH_RAW       = rhraw;
    assign ifs[g].CLEAR        = clr;
    assign t_out[g]   = ifs[g].TEMP_OUT;
    assign rh_out[g]  = ifs[g].RH_OUT;
    assign mn[g]      = ifs[g].TEMP_MIN;
    assign mx[g]      = ifs[g].TEMP_MAX;
    assign o_valid[g] = ifs[g].OUT_VALID;
    assign busy[g]    = ifs[g].BUSY;
    assign ovr[g]     = ifs[g].OVERRUN;
  end
  int al[3] = '{0, 2, 0};
  int sc[3] = '{10, 10, 100};
  int acc_t[3], acc_rh[3], n[3], pend[3], r_t[3], r_rh[3], m_t[3], m_rh[3], m_min[3], m_max[3];
  bit m_valid[3], m_ovr[3], armed[3];
  int tests = 0, fails = 0;
  task automatic model_reset();
    foreach (n[k]) begin
      acc_t[k] = 0; acc_rh[k] = 0; n[k] = 0; pend[k] = 0; r_t[k] = 0; r_rh[k] = 0;
      m_t[k] = 0; m_rh[k] = 0; m_min[k] = 32767; m_max[k] = -32768;
      m_valid[k] = 0; m_ovr[k] = 0; armed[k] = 0;
    end
  endtask
  // pend counts the 17 edges from the batch-completing sample to the result; samples are dropped meanwhile
  task automatic clk_step();
    @(posedge clk);
    if (rst_n) for (int k = 0; k < 3; k++) begin
      bit b;
      b = pend[k] > 0;
      m_valid[k] = 0;
      if (clr) begin
        m_ovr[k] = 0; armed[k] = 0; m_min[k] = 32767; m_max[k] = -32768;
      end
      if (pend[k] > 0) begin
        pend[k]--;
        if (pend[k] == 0) begin
          m_t[k] = r_t[k]; m_rh[k] = r_rh[k]; m_valid[k] = 1;
          if (!armed[k] || r_t[k] < m_min[k]) m_min[k] = r_t[k];
          if (!armed[k] || r_t[k] > m_max[k]) m_max[k] = r_t[k];
          armed[k] = 1;
        end
      end
      if (sv) begin
        if (b) m_ovr[k] = 1;
        else begin
          acc_t[k] += int'(traw); acc_rh[k] += int'(rhraw); n[k]++;
          if (n[k] == (1 << al[k])) begin
            r_t[k]  = int'(longint'(acc_t[k] >> al[k]) * 165 * sc[k] / 65536) - 40 * sc[k];
            r_rh[k] = int'(longint'(acc_rh[k] >> al[k]) * 100 * sc[k] / 65536);
            pend[k] = 17; acc_t[k] = 0; acc_rh[k] = 0; n[k] = 0;
          end
        end
      end
    end
    #1;
  endtask
  task automatic sample(input logic [15:0] t, input logic [15:0] rh);
    sv = 1'b1; traw = t; rhraw = rh;
    clk_step();
    sv = 1'b0;
  endtask
  task automatic idle(input int cycles);
    repeat (cycles) clk_step();
  endtask
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (t_out[k] !== 16'h0 || rh_out[k] !== 16'h0 || o_valid[k] !== 1'b0 || mn[k] !== 16'h7FFF ||
          mx[k] !== 16'h8000 || busy[k] !== 1'b0 || ovr[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: got t=%h rh=%h v=%b min=%h max=%h busy=%b ovr=%b, want 0 0 0 7fff 8000 0 0",
                 k, t_out[k], rh_out[k], o_valid[k], mn[k], mx[k], busy[k], ovr[k]);
      end
    end
  endtask
  task automatic test_avg4();
    int nv = 0;
    for (int i = 1; i <= 4; i++) begin
      sample(16'(i * 4096), 16'(i * 4096));
      repeat (20) begin
        clk_step();
        if (o_valid[1]) nv++;
      end
    end
    tests++;
    if (nv != 1) begin fails++; $display("FAIL avg4_count: got %0d strobes, want 1", nv); end
    tests++;
    if (t_out[1] !== 16'(-143) || rh_out[1] !== 16'd156) begin
      fails++; $display("FAIL avg4_value: got t=%0d rh=%0d, want -143 156", $signed(t_out[1]), rh_out[1]);
    end
    tests++;
    if (t_out[0] !== 16'd12 || rh_out[0] !== 16'd250) begin
      fails++; $display("FAIL avg1_value: got t=%0d rh=%0d, want 12 250", $signed(t_out[0]), rh_out[0]);
    end
  endtask
  task automatic test_latency();
    int lat = 0;
    sample(16'h6666, 16'h8000);
    while (o_valid[0] !== 1'b1 && lat < 40) begin
      clk_step();
      lat++;
    end
    tests++;
    if (lat != 17) begin fails++; $display("FAIL latency: got %0d edges, want 17", lat); end
    tests++;
    if (t_out[0] !== 16'd259 || rh_out[0] !== 16'd500) begin
      fails++; $display("FAIL latency_value: got t=%0d rh=%0d, want 259 500", $signed(t_out[0]), rh_out[0]);
    end
    tests++;
    if (t_out[2] !== 16'd2599 || rh_out[2] !== 16'd5000 || o_valid[2] !== 1'b1) begin
      fails++; $display("FAIL scale100_value: got t=%0d rh=%0d v=%b, want 2599 5000 1", $signed(t_out[2]), rh_out[2], o_valid[2]);
    end
    clk_step();
    tests++;
    if (o_valid[0] !== 1'b0) begin fails++; $display("FAIL strobe_width: got valid=%b, want 0", o_valid[0]); end
  endtask
  task automatic test_minmax();
    clr = 1'b1; clk_step(); clr = 1'b0;
    sample(16'h0000, 16'h0000);
    idle(20);
    tests++;
    if (t_out[0] !== 16'hFE70) begin fails++; $display("FAIL zero_code: got t=%h, want fe70", t_out[0]); end
    sample(16'hFFFF, 16'hFFFF);
    idle(20);
    tests++;
    if (t_out[0] !== 16'd1249 || mn[0] !== 16'hFE70 || mx[0] !== 16'd1249) begin
      fails++; $display("FAIL minmax: got t=%0d min=%0d max=%0d, want 1249 -400 1249", $signed(t_out[0]), $signed(mn[0]), $signed(mx[0]));
    end
    tests++;
    if (t_out[2] !== 16'd12499 || rh_out[2] !== 16'd9999) begin
      fails++; $display("FAIL scale100_full: got t=%0d rh=%0d, want 12499 9999", $signed(t_out[2]), rh_out[2]);
    end
  endtask
  task automatic test_overrun();
    sample(16'h3000, 16'h1234);
    idle(4);
    sample(16'hFFFF, 16'hFFFF);
    idle(20);
    tests++;
    if (ovr[0] !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b, want 1", ovr[0]); end
    tests++;
    if (t_out[0] !== 16'(-91)) begin fails++; $display("FAIL overrun_drop: got t=%0d, want -91", $signed(t_out[0])); end
    clr = 1'b1; clk_step(); clr = 1'b0;
    tests++;
    if (ovr[0] !== 1'b0 || mn[0] !== 16'h7FFF || mx[0] !== 16'h8000) begin
      fails++; $display("FAIL clear: got ovr=%b min=%h max=%h, want 0 7fff 8000", ovr[0], mn[0], mx[0]);
    end
  endtask
  task automatic test_clear_corners();
    sample(16'h2000, 16'h0000);
    idle(2);
    sv = 1'b1; clr = 1'b1; clk_step(); sv = 1'b0; clr = 1'b0;
    tests++;
    if (ovr[0] !== 1'b1) begin fails++; $display("FAIL clear_vs_overrun: got ovr=%b, want 1", ovr[0]); end
    idle(20);
    sample(16'h9000, 16'h0000);
    idle(16);
    clr = 1'b1; clk_step(); clr = 1'b0;
    tests++;
    if (o_valid[0] !== 1'b1 || t_out[0] !== 16'd528 || mn[0] !== 16'd528 || mx[0] !== 16'd528) begin
      fails++; $display("FAIL clear_in_load: got v=%b t=%0d min=%0d max=%0d, want 1 528 528 528",
                        o_valid[0], $signed(t_out[0]), $signed(mn[0]), $signed(mx[0]));
    end
    tests++;
    if (ovr[0] !== 1'b0) begin fails++; $display("FAIL clear_in_load_ovr: got ovr=%b, want 0", ovr[0]); end
  endtask
  task automatic test_reset_mid_mult();
    int nv = 0, st = 0, sr = 0, et, er;
    logic [15:0] t, r;
    sample(16'h5555, 16'h5555);
    idle(7);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    test_reset();
    clk_step();
    clk_step();
    rst_n = 1'b1;
    repeat (20) begin
      clk_step();
      if (o_valid[0] || o_valid[1] || o_valid[2]) nv++;
    end
    tests++;
    if (nv != 0) begin fails++; $display("FAIL reset_abort: got %0d strobes, want 0", nv); end
    for (int i = 0; i < 4; i++) begin
      t = 16'($urandom); r = 16'($urandom);
      st += int'(t); sr += int'(r);
      sample(t, r);
      idle(20);
    end
    et = int'(longint'(st / 4) * 1650 / 65536) - 400;
    er = int'(longint'(sr / 4) * 1000 / 65536);
    tests++;
    if (t_out[1] !== 16'(et) || rh_out[1] !== 16'(er)) begin
      fails++; $display("FAIL after_reset_batch: got t=%0d rh=%0d, want %0d %0d", $signed(t_out[1]), rh_out[1], et, er);
    end
  endtask
  task automatic run_random(input int cycles, input int pct);
    repeat (cycles) begin
      sv = $urandom_range(0, 99) < pct;
      traw = 16'($urandom);
      rhraw = 16'($urandom);
      clr = $urandom_range(0, 99) < 2;
      clk_step();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (o_valid[k] !== m_valid[k] || t_out[k] !== 16'(m_t[k]) || rh_out[k] !== 16'(m_rh[k]) ||
            mn[k] !== 16'(m_min[k]) || mx[k] !== 16'(m_max[k]) || ovr[k] !== m_ovr[k] || busy[k] !== (pend[k] > 0)) begin
          fails++;
          $display("FAIL rand[%0d] got/want: v=%b/%b t=%h/%h rh=%h/%h min=%h/%h max=%h/%h ovr=%b/%b busy=%b/%b",
                   k, o_valid[k], m_valid[k], t_out[k], 16'(m_t[k]), rh_out[k], 16'(m_rh[k]), mn[k], 16'(m_min[k]),
                   mx[k], 16'(m_max[k]), ovr[k], m_ovr[k], busy[k], pend[k] > 0);
        end
      end
    end
    sv = 1'b0;
    clr = 1'b0;
  endtask
  task automatic test_back_to_back();
    run_random(80, 100);
  endtask
  task automatic test_random();
    run_random(1500, 15);
  endtask
  initial begin
    rst_n = 1'b0; sv = 1'b0; clr = 1'b0; traw = '0; rhraw = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_avg4();
    test_latency();
    test_minmax();
    test_overrun();
    test_clear_corners();
    test_reset_mid_mult();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
